// File: rtl/simple_processor_pkg.sv
// -----------------------------------------------------------------------------
// simple_processor_pkg
// Shared types and constants for the simple processor datapath.
//   DATA_WIDTH          : datapath width of registers and ALU operands
//   func_t              : gate ALU function code (AND, OR, XOR, NOT)
//   gate_issue_state_t  : sequencing states of gate_issue_unit
//   gate_issue_next()   : next-state helper for the issue FSM
// -----------------------------------------------------------------------------
package simple_processor_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    FUNC_AND = 2'd0,
    FUNC_OR  = 2'd1,
    FUNC_XOR = 2'd2,
    FUNC_NOT = 2'd3
  } func_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } gate_issue_state_t;

  // Fixed four-step sequence; only IDLE waits on an input.
  function automatic gate_issue_state_t gate_issue_next(
    input gate_issue_state_t cur,
    input logic              accept
  );
    gate_issue_state_t nxt;
    case (cur)
      IDLE:    nxt = accept ? READ : IDLE;
      READ:    nxt = EXEC;
      EXEC:    nxt = WB;
      WB:      nxt = IDLE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/gate_issue_unit_regfile.sv
// -----------------------------------------------------------------------------
// gate_regfile
// NUM_REGS x DATA_WIDTH register file for the gate issue unit.
//   clk_i, arst_ni        : clock, asynchronous active-low reset (clears all)
//   we_i/waddr_i/wdata_i  : single write port; writes to r0 are dropped
//   cap_en_i              : capture both read ports into the operand registers
//   raddr1_i/raddr2_i     : read addresses for the captured operands
//   rdata1_o/rdata2_o     : operand registers (hold until next capture)
//   dbg_addr_i/dbg_data_o : combinational debug read
// r0 always reads as zero.
// -----------------------------------------------------------------------------
module gate_regfile
  import simple_processor_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int REG_ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  cap_en_i,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [DATA_WIDTH-1:0] rdata2_o,
  input  logic [REG_ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_WIDTH-1:0] dbg_data_o
);

  localparam logic [REG_ADDR_W-1:0] ADDR_ZERO = {REG_ADDR_W{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd1_s;
  logic [DATA_WIDTH-1:0] rd2_s;
  logic [DATA_WIDTH-1:0] rdata1_r;
  logic [DATA_WIDTH-1:0] rdata2_r;

  // Storage array: cleared on reset, written through the single write port.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= DATA_ZERO;
      end
    end else if (we_i && (waddr_i != ADDR_ZERO)) begin
      regs_r[waddr_i] <= wdata_i;
    end
  end

  // r0 is forced to zero on every read path, independent of storage contents.
  assign rd1_s      = (raddr1_i   == ADDR_ZERO) ? DATA_ZERO : regs_r[raddr1_i];
  assign rd2_s      = (raddr2_i   == ADDR_ZERO) ? DATA_ZERO : regs_r[raddr2_i];
  assign dbg_data_o = (dbg_addr_i == ADDR_ZERO) ? DATA_ZERO : regs_r[dbg_addr_i];

  // Operand registers: sample both read ports when capture is enabled.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rdata1_r <= DATA_ZERO;
      rdata2_r <= DATA_ZERO;
    end else if (cap_en_i) begin
      rdata1_r <= rd1_s;
      rdata2_r <= rd2_s;
    end
  end

  assign rdata1_o = rdata1_r;
  assign rdata2_o = rdata2_r;

endmodule

// File: rtl/gate_issue_unit.sv
// -----------------------------------------------------------------------------
// gate_issue_unit
// Operand-supply and write-back controller for the external gate ALU.
// Accepts one instruction per valid/ready handshake, reads rs1/rs2 from the
// internal register file, presents them with func to the ALU during EXEC,
// captures the ALU result and writes it back to rd in WB.
//   instr_*      : instruction handshake and fields (ready only in IDLE)
//   load_*       : register initialisation port, honoured only in IDLE
//   rs1_data_o, rs2_data_o, func_o : ALU operands/function (valid in EXEC)
//   rd_data_i    : combinational ALU result
//   done_o       : one-cycle pulse in WB; result_o carries the written value
//   dbg_*        : combinational register read
// Sequence: accept (cycle 0) -> READ (1) -> EXEC (2) -> WB (3) -> IDLE (4).
// -----------------------------------------------------------------------------
module gate_issue_unit
  import simple_processor_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int REG_ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  func_t                 instr_func_i,
  input  logic [REG_ADDR_W-1:0] instr_rd_i,
  input  logic [REG_ADDR_W-1:0] instr_rs1_i,
  input  logic [REG_ADDR_W-1:0] instr_rs2_i,
  input  logic                  load_en_i,
  input  logic [REG_ADDR_W-1:0] load_addr_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  output logic [DATA_WIDTH-1:0] rs1_data_o,
  output logic [DATA_WIDTH-1:0] rs2_data_o,
  output func_t                 func_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  input  logic [REG_ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_WIDTH-1:0] dbg_data_o
);

  localparam logic [REG_ADDR_W-1:0] ADDR_ZERO = {REG_ADDR_W{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  gate_issue_state_t     state_r;
  gate_issue_state_t     next_state_s;
  logic                  ready_r;
  logic                  done_r;
  logic                  accept_s;
  func_t                 func_lat_r;
  func_t                 func_out_r;
  logic [REG_ADDR_W-1:0] rd_r;
  logic [REG_ADDR_W-1:0] rs1_r;
  logic [REG_ADDR_W-1:0] rs2_r;
  logic [DATA_WIDTH-1:0] result_r;
  logic                  rf_we_s;
  logic [REG_ADDR_W-1:0] rf_waddr_s;
  logic [DATA_WIDTH-1:0] rf_wdata_s;

  // ready_r is a registered copy of (state_r == IDLE), so accept is a clean AND.
  assign accept_s     = instr_valid_i & ready_r;
  assign next_state_s = gate_issue_next(state_r, accept_s);

  // Sequencer plus registered ready/done decoded from the next state.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ready_r <= (next_state_s == IDLE);
      done_r  <= (next_state_s == WB);
    end
  end

  // Instruction fields are latched at the acceptance edge.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      func_lat_r <= FUNC_AND;
      rd_r       <= ADDR_ZERO;
      rs1_r      <= ADDR_ZERO;
      rs2_r      <= ADDR_ZERO;
    end else if (accept_s) begin
      func_lat_r <= instr_func_i;
      rd_r       <= instr_rd_i;
      rs1_r      <= instr_rs1_i;
      rs2_r      <= instr_rs2_i;
    end
  end

  // func_o updates together with the operand registers so all three ALU
  // inputs change only on entry to EXEC and hold everywhere else.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      func_out_r <= FUNC_AND;
    end else if (state_r == READ) begin
      func_out_r <= func_lat_r;
    end
  end

  // ALU result captured at the end of EXEC; it doubles as result_o, which
  // therefore shows the new value in WB and holds it afterwards.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      result_r <= DATA_ZERO;
    end else if (state_r == EXEC) begin
      result_r <= rd_data_i;
    end
  end

  // Write-port mux: loads own the port in IDLE, write-back owns it in WB.
  always_comb begin
    rf_we_s    = 1'b0;
    rf_waddr_s = ADDR_ZERO;
    rf_wdata_s = DATA_ZERO;
    case (state_r)
      IDLE: begin
        rf_we_s    = load_en_i;
        rf_waddr_s = load_addr_i;
        rf_wdata_s = load_data_i;
      end
      WB: begin
        rf_we_s    = 1'b1;
        rf_waddr_s = rd_r;
        rf_wdata_s = result_r;
      end
      default: begin
        rf_we_s    = 1'b0;
        rf_waddr_s = ADDR_ZERO;
        rf_wdata_s = DATA_ZERO;
      end
    endcase
  end

  gate_regfile #(
    .NUM_REGS   (NUM_REGS),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clk_i      (clk_i),
    .arst_ni    (arst_ni),
    .we_i       (rf_we_s),
    .waddr_i    (rf_waddr_s),
    .wdata_i    (rf_wdata_s),
    .cap_en_i   (state_r == READ),
    .raddr1_i   (rs1_r),
    .raddr2_i   (rs2_r),
    .rdata1_o   (rs1_data_o),
    .rdata2_o   (rs2_data_o),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o)
  );

  assign instr_ready_o = ready_r;
  assign done_o        = done_r;
  assign result_o      = result_r;
  assign func_o        = func_out_r;

endmodule

// File: tb/tb_gate_issue_unit.sv
// Bench for gate_issue_unit: table of instructions with expected results, a
// result scoreboard checked on every done_o pulse, and hand-written sequences
// for the handshake, load-while-busy and reset-abort corner cases.
module tb_gate_issue_unit;
  import simple_processor_pkg::*;

  localparam int NR = 16;
  localparam int AW = 4;
  localparam int DW = DATA_WIDTH;

  logic          clk;
  logic          arst_n;
  logic          instr_valid;
  logic          instr_ready;
  func_t         instr_func;
  logic [AW-1:0] instr_rd, instr_rs1, instr_rs2;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic [DW-1:0] rs1_data, rs2_data;
  func_t         func_out;
  logic [DW-1:0] rd_data;
  logic          done;
  logic [DW-1:0] result;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  gate_issue_unit #(.NUM_REGS(NR), .REG_ADDR_W(AW)) dut (
    .clk_i(clk), .arst_ni(arst_n),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
    .instr_func_i(instr_func), .instr_rd_i(instr_rd),
    .instr_rs1_i(instr_rs1), .instr_rs2_i(instr_rs2),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data),
    .rs1_data_o(rs1_data), .rs2_data_o(rs2_data), .func_o(func_out),
    .rd_data_i(rd_data), .done_o(done), .result_o(result),
    .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
  );

  // External gate ALU
  always_comb begin
    case (func_out)
      FUNC_AND: rd_data = rs1_data & rs2_data;
      FUNC_OR:  rd_data = rs1_data | rs2_data;
      FUNC_XOR: rd_data = rs1_data ^ rs2_data;
      FUNC_NOT: rd_data = ~rs1_data;
      default:  rd_data = '0;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int acc_q[$];
  logic [DW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (arst_n) begin
      if (instr_valid && instr_ready) acc_q.push_back(cyc);
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          check("result", 32'(result), 32'(exp_q.pop_front()));
          if (acc_q.size() != 0) check("latency", 32'(cyc - acc_q.pop_front()), 32'd3);
          else check("latency_noaccept", 32'd1, 32'd0);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", 32'(instr_ready), 32'd1);
  endtask

  task automatic issue(input func_t f, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic [DW-1:0] e, input bit push,
                       output int acc);
    wait_ready();
    instr_valid = 1'b1;
    instr_func = f; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    acc = cyc - 1;
    instr_valid = 1'b0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ready();
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic dbg(input logic [AW-1:0] a, input logic [DW-1:0] e, input string name);
    dbg_addr = a;
    #1;
    check(name, 32'(dbg_data), 32'(e));
  endtask

  task automatic drain();
    int n = 0;
    while ((!instr_ready || exp_q.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    func_t         func;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[6];
  int   acc[6];
  int   a0, a1, d0;

  initial begin
    vecs[0] = '{FUNC_AND, 4'd3, 4'd1, 4'd2, 8'h30};
    vecs[1] = '{FUNC_OR,  4'd6, 4'd1, 4'd2, 8'hFC};
    vecs[2] = '{FUNC_XOR, 4'd7, 4'd1, 4'd2, 8'hCC};
    vecs[3] = '{FUNC_NOT, 4'd4, 4'd1, 4'd2, 8'h0F};
    vecs[4] = '{FUNC_XOR, 4'd0, 4'd1, 4'd1, 8'h00};
    vecs[5] = '{FUNC_XOR, 4'd0, 4'd1, 4'd2, 8'hCC};

    arst_n = 1'b0; instr_valid = 1'b0; instr_func = FUNC_AND;
    instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0; dbg_addr = '0;
    #22 arst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    for (int i = 0; i < NR; i++) dbg(AW'(i), 8'h00, "reset_reg");
    check("reset_ready", 32'(instr_ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_rs1", 32'(rs1_data), 32'd0);
    check("reset_rs2", 32'(rs2_data), 32'd0);
    check("reset_func", 32'(func_out), 32'(FUNC_AND));

    load(4'd1, 8'hF0);
    load(4'd2, 8'h3C);
    dbg(4'd1, 8'hF0, "load_r1");
    dbg(4'd2, 8'h3C, "load_r2");

    // Table: each instruction offered as soon as ready returns
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].func, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].exp, 1'b1, acc[i]);
      if (i > 0) check("accept_spacing", 32'(acc[i] - acc[i-1]), 32'd4);
    end
    drain();
    for (int i = 0; i < 6; i++)
      dbg(vecs[i].rd, (vecs[i].rd == 4'd0) ? 8'h00 : vecs[i].exp, "wb_reg");

    load(4'd0, 8'hAA);
    dbg(4'd0, 8'h00, "r0_load_dropped");

    // Valid held high across two acceptances; load pulse in EXEC is ignored
    wait_ready();
    instr_valid = 1'b1; instr_func = FUNC_AND;
    instr_rd = 4'd8; instr_rs1 = 4'd1; instr_rs2 = 4'd2;
    exp_q.push_back(8'h30);
    @(posedge clk); #1;                     // accepted -> READ
    a0 = cyc - 1;
    check("hs_ready_read", 32'(instr_ready), 32'd0);
    @(posedge clk); #1;                     // EXEC
    check("hs_ready_exec", 32'(instr_ready), 32'd0);
    load_en = 1'b1; load_addr = 4'd1; load_data = 8'h55;
    @(posedge clk); #1;                     // WB
    load_en = 1'b0;
    check("hs_ready_wb", 32'(instr_ready), 32'd0);
    @(posedge clk); #1;                     // IDLE, valid still high
    check("hs_ready_idle", 32'(instr_ready), 32'd1);
    exp_q.push_back(8'h30);
    @(posedge clk); #1;                     // second acceptance
    a1 = cyc - 1;
    check("hs_spacing", 32'(a1 - a0), 32'd4);
    check("hs_ready_read2", 32'(instr_ready), 32'd0);
    instr_valid = 1'b0;
    drain();
    dbg(4'd1, 8'hF0, "busy_load_ignored");
    dbg(4'd8, 8'h30, "hs_wb_reg");

    // Reset during EXEC aborts the instruction
    issue(FUNC_AND, 4'd5, 4'd1, 4'd2, 8'h30, 1'b0, a0);
    @(posedge clk); #1;                     // EXEC
    check("exec_rs1", 32'(rs1_data), 32'hF0);
    check("exec_rs2", 32'(rs2_data), 32'h3C);
    d0 = done_cnt;
    arst_n = 1'b0;
    #1;
    check("arst_ready", 32'(instr_ready), 32'd1);
    check("arst_done", 32'(done), 32'd0);
    #10 arst_n = 1'b1;
    acc_q.delete();
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    check("abort_ready", 32'(instr_ready), 32'd1);
    dbg(4'd5, 8'h00, "abort_r5");
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
